gcd_host_ctrl: RTL and testbench



---
 rtl/gcd_host_ctrl.sv | 112 +++++++++++
 tb/tb_gcd_host_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_host_ctrl.sv
// Initiator-side controller for a GCD engine: takes one operand pair at a time,
// pulses the engine start, waits for done or timeout, and returns the response.
module gcd_host_ctrl #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNTW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NBITS-1:0] rsp_result,
    output logic             rsp_error,
    output logic [NBITS-1:0] eng_a,
    output logic [NBITS-1:0] eng_b,
    output logic             eng_start,
    input  logic [NBITS-1:0] eng_result,
    input  logic             eng_done,
    output logic             busy,
    output logic [CNTW-1:0]  cmpl_count
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e           state_q;
    logic [NBITS-1:0] eng_a_q;
    logic [NBITS-1:0] eng_b_q;
    logic             eng_start_q;
    logic             rsp_valid_q;
    logic [NBITS-1:0] rsp_result_q;
    logic             rsp_error_q;
    logic [CNTW-1:0]  cmpl_count_q;
    logic [TW-1:0]    tmo_cnt_q;

    // Single sequential FSM; every output except the two status flags is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            eng_a_q      <= '0;
            eng_b_q      <= '0;
            eng_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            cmpl_count_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        eng_a_q     <= req_a;
                        eng_b_q     <= req_b;
                        eng_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_start_q <= 1'b0;
                    tmo_cnt_q   <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a timeout landing on the same cycle.
                    if (eng_done) begin
                        rsp_result_q <= eng_result;
                        rsp_error_q  <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (tmo_cnt_q == TLAST) begin
                        rsp_result_q <= '0;
                        rsp_error_q  <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        cmpl_count_q <= cmpl_count_q + CNTW'(1);
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign eng_a      = eng_a_q;
    assign eng_b      = eng_b_q;
    assign eng_start  = eng_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign cmpl_count = cmpl_count_q;

endmodule

// File: tb/tb_gcd_host_ctrl.sv
// Directed bench for gcd_host_ctrl; the engine is played by hand-timed eng_done pulses.
module tb_gcd_host_ctrl;

    localparam int unsigned NBITS = 32;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CNTW  = 4;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [NBITS-1:0] req_a;
    logic [NBITS-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [NBITS-1:0] rsp_result;
    logic             rsp_error;
    logic [NBITS-1:0] eng_a;
    logic [NBITS-1:0] eng_b;
    logic             eng_start;
    logic [NBITS-1:0] eng_result;
    logic             eng_done;
    logic             busy;
    logic [CNTW-1:0]  cmpl_count;

    int total = 0;
    int bad   = 0;

    gcd_host_ctrl #(.NBITS(NBITS), .TIMEOUT(TMO), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
        .eng_result(eng_result), .eng_done(eng_done), .busy(busy), .cmpl_count(cmpl_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one request while in IDLE; returns one edge after acceptance (ISSUE).
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    // Full transaction with done raised lat cycles into WAIT, then immediate handoff.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat);
        send(a, b);
        repeat (lat) tick();
        eng_done   = 1'b1;
        eng_result = res;
        tick();
        eng_done   = 1'b0;
        chk("txn_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("txn_rsp_result", rsp_result, res);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        eng_result = '0;
        eng_done   = 1'b0;
        repeat (2) tick();

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_eng_a", eng_a, 32'd0);
        chk("rst_cmpl", 32'(cmpl_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic: 48,18 -> 6, done four cycles after the start cycle
        send(48, 18);
        chk("basic_start", 32'(eng_start), 32'd1);
        chk("basic_eng_a", eng_a, 32'd48);
        chk("basic_eng_b", eng_b, 32'd18);
        chk("basic_req_ready", 32'(req_ready), 32'd0);
        chk("basic_busy", 32'(busy), 32'd1);
        tick();
        chk("basic_start_drop", 32'(eng_start), 32'd0);
        repeat (3) tick();
        chk("basic_no_rsp_yet", 32'(rsp_valid), 32'd0);
        eng_done   = 1'b1;
        eng_result = 6;
        tick();
        eng_done = 1'b0;
        chk("basic_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("basic_rsp_result", rsp_result, 32'd6);
        chk("basic_rsp_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("basic_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("basic_cmpl", 32'(cmpl_count), 32'd1);
        chk("basic_idle", 32'(req_ready), 32'd1);

        // Backpressure: 35,14 -> 7 held while a new request waits
        send(35, 14);
        tick();
        eng_done   = 1'b1;
        eng_result = 7;
        tick();
        eng_done  = 1'b0;
        req_valid = 1'b1;
        req_a     = 99;
        req_b     = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_result", rsp_result, 32'd7);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_eng_a_held", eng_a, 32'd35);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_handoff_eng_a", eng_a, 32'd35);
        chk("bp_handoff_nostart", 32'(eng_start), 32'd0);
        chk("bp_cmpl", 32'(cmpl_count), 32'd2);
        tick();
        req_valid = 1'b0;
        chk("bp_accept_eng_a", eng_a, 32'd99);
        chk("bp_accept_start", 32'(eng_start), 32'd1);
        tick();
        eng_done   = 1'b1;
        eng_result = 1;
        tick();
        eng_done  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_cmpl2", 32'(cmpl_count), 32'd3);

        // Timeout: no done -> rsp_valid after edge 17 past acceptance edge
        send(2, 3);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_early", 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_rsp_result", rsp_result, 32'd0);
        chk("tmo_rsp_error", 32'(rsp_error), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tmo_cmpl", 32'(cmpl_count), 32'd4);

        // Race: done on the 16th WAIT cycle beats the timeout
        send(10, 15);
        repeat (16) tick();
        eng_done   = 1'b1;
        eng_result = 5;
        tick();
        eng_done = 1'b0;
        chk("race_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("race_rsp_result", rsp_result, 32'd5);
        chk("race_rsp_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("race_cmpl", 32'(cmpl_count), 32'd5);

        // Reset three cycles into WAIT
        send(100, 75);
        repeat (3) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd1);
        chk("mid_eng_a", eng_a, 32'd0);
        chk("mid_eng_b", eng_b, 32'd0);
        chk("mid_cmpl", 32'(cmpl_count), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(9, 6, 3, 2);
        chk("mid_after_cmpl", 32'(cmpl_count), 32'd1);

        // Stray done while idle
        eng_done   = 1'b1;
        eng_result = 77;
        tick();
        eng_done = 1'b0;
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);

        // Counter wrap: 17 completions from zero leave 1 in a 4-bit count
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) do_req(32'(i + 2), 32'(i + 1), 32'(i + 1), 1);
        chk("wrap_16", 32'(cmpl_count), 32'd0);
        do_req(21, 14, 7, 1);
        chk("wrap_17", 32'(cmpl_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
